hls_run_sequencer: RTL and testbench

HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

---
 rtl/hls_run_sequencer.sv | 138 +++++++++++++
 tb/tb_hls_run_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// Sequences one accelerator run: stream words into slave RAM, pulse start, time the run, read results back out.
// Writes are combinational with ld_valid; result words wait in RD_OUT until rd_ready, and no command is taken until REPORT.
module hls_run_sequencer #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 9,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 200000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_ld_base,
  input  logic [7:0]        cmd_ld_words,
  input  logic [ADDR_W-1:0] cmd_rd_base,
  input  logic [7:0]        cmd_rd_words,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              acc_start,
  input  logic              acc_done,
  output logic              S_oe_ram,
  output logic              S_we_ram,
  output logic [ADDR_W-1:0] S_addr_ram,
  output logic [DATA_W-1:0] S_Wdata_ram,
  output logic [6:0]        S_data_ram_size,
  input  logic [DATA_W-1:0] Sout_Rdata_ram,
  input  logic              Sout_DataRdy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              status_valid,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              timeout_flag
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, RD_REQ, RD_WAIT, RD_OUT, REPORT
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ld_base_q;
  logic [ADDR_W-1:0]  rd_base_q;
  logic [7:0]         ld_words_q;
  logic [7:0]         rd_words_q;
  logic [7:0]         idx;
  logic [CNT_W-1:0]   counter;
  logic [ADDR_W-1:0]  ld_addr;
  logic [ADDR_W-1:0]  rd_addr;

  // Byte addresses wrap naturally at 2^ADDR_W through truncation.
  assign ld_addr = ld_base_q + ADDR_W'(32'(idx) * BYTES);
  assign rd_addr = rd_base_q + ADDR_W'(32'(idx) * BYTES);

  assign cmd_ready       = (state == IDLE);
  assign ld_ready        = (state == LOAD);
  assign acc_start       = (state == START);
  assign rd_valid        = (state == RD_OUT);
  assign status_valid    = (state == REPORT);
  assign busy            = (state != IDLE);
  assign S_we_ram        = (state == LOAD) && ld_valid;
  assign S_oe_ram        = (state == RD_REQ);
  assign S_Wdata_ram     = S_we_ram ? ld_data : '0;
  assign S_addr_ram      = S_we_ram ? ld_addr : (S_oe_ram ? rd_addr : '0);
  assign S_data_ram_size = (S_we_ram || S_oe_ram) ? 7'(DATA_W) : 7'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ld_base_q    <= '0;
      rd_base_q    <= '0;
      ld_words_q   <= '0;
      rd_words_q   <= '0;
      idx          <= '0;
      counter      <= '0;
      rd_data      <= '0;
      run_cycles   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ld_base_q    <= cmd_ld_base;
            rd_base_q    <= cmd_rd_base;
            ld_words_q   <= cmd_ld_words;
            rd_words_q   <= cmd_rd_words;
            idx          <= '0;
            timeout_flag <= 1'b0;
            state        <= (cmd_ld_words != 8'd0) ? LOAD : START;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            idx <= idx + 8'd1;
            if (idx == ld_words_q - 8'd1) state <= START;
          end
        end
        START: begin
          counter <= CNT_W'(1);
          state   <= RUN;
        end
        RUN: begin
          // A done arriving on the limit cycle still counts as a normal finish.
          if (acc_done) begin
            run_cycles <= counter;
            idx        <= '0;
            state      <= (rd_words_q != 8'd0) ? RD_REQ : REPORT;
          end else if (counter == CNT_W'(TIMEOUT)) begin
            timeout_flag <= 1'b1;
            run_cycles   <= CNT_W'(TIMEOUT);
            state        <= REPORT;
          end else if (counter != {CNT_W{1'b1}}) begin
            counter <= counter + CNT_W'(1);
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (Sout_DataRdy) begin
            rd_data <= Sout_Rdata_ram;
            state   <= RD_OUT;
          end
        end
        RD_OUT: begin
          if (rd_ready) begin
            idx   <= idx + 8'd1;
            state <= (idx == rd_words_q - 8'd1) ? REPORT : RD_REQ;
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Randomized bench for hls_run_sequencer: per-command expectation queues derived from command fields, checked every cycle.
module tb_hls_run_sequencer;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 32;
  localparam int TMO    = 8;

  logic              clock, reset;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_ld_base, cmd_rd_base;
  logic [7:0]        cmd_ld_words, cmd_rd_words;
  logic              ld_valid, ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              acc_start, acc_done, acc_done_resp, acc_done_spur;
  logic              S_oe_ram, S_we_ram;
  logic [ADDR_W-1:0] S_addr_ram;
  logic [DATA_W-1:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [6:0]        S_data_ram_size;
  logic              Sout_DataRdy;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy, status_valid, timeout_flag;
  logic [CNT_W-1:0]  run_cycles;

  assign acc_done = acc_done_resp | acc_done_spur;

  hls_run_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld_base(cmd_ld_base), .cmd_ld_words(cmd_ld_words),
    .cmd_rd_base(cmd_rd_base), .cmd_rd_words(cmd_rd_words),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .acc_start(acc_start), .acc_done(acc_done),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .status_valid(status_valid),
    .run_cycles(run_cycles), .timeout_flag(timeout_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: expected bus activity for the command in flight.
  logic [DATA_W-1:0] mem [0:511];
  logic [ADDR_W-1:0] exp_wr_addr[$];
  logic [DATA_W-1:0] exp_wr_dat[$];
  logic [ADDR_W-1:0] exp_rd_addr[$];
  logic [DATA_W-1:0] exp_rd_dat[$];
  int                exp_starts, exp_status;
  logic [CNT_W-1:0]  exp_run;
  logic              exp_flag;

  logic [ADDR_W-1:0] obs_wr[$];
  logic [ADDR_W-1:0] obs_oe[$];
  int                obs_status;
  logic [CNT_W-1:0]  obs_run;
  logic              obs_flag;

  int                cur_delay;
  bit                stall_mode;

  logic              prev_rv, prev_rr, prev_start, prev_stat;
  logic [DATA_W-1:0] prev_rd;
  logic [CNT_W-1:0]  hold_run;
  logic              hold_flag;
  logic [8:0]        bad;

  always @(negedge clock) begin
    if (reset) begin
      prev_rv = 0; prev_rr = 0; prev_start = 0; prev_stat = 0;
      hold_run = '0; hold_flag = 1'b0;
    end else begin
      bad = '0;
      if (S_oe_ram && S_we_ram) bad[0] = 1'b1;
      if (S_data_ram_size !== ((S_oe_ram || S_we_ram) ? 7'd64 : 7'd0)) bad[1] = 1'b1;
      if (!S_oe_ram && !S_we_ram && (S_addr_ram !== '0 || S_Wdata_ram !== '0)) bad[2] = 1'b1;
      if (busy === cmd_ready) bad[3] = 1'b1;
      if (S_we_ram !== (ld_ready && ld_valid)) bad[4] = 1'b1;
      if (prev_rv && !prev_rr && (!rd_valid || rd_data !== prev_rd)) bad[5] = 1'b1;
      if (prev_start && acc_start) bad[6] = 1'b1;
      if (prev_stat && status_valid) bad[7] = 1'b1;
      if (!busy && (run_cycles !== hold_run || timeout_flag !== hold_flag)) bad[8] = 1'b1;
      check("invariants", 64'(bad), 64'(0));

      if (S_we_ram) begin
        obs_wr.push_back(S_addr_ram);
        check("write_expected", 64'(exp_wr_addr.size() != 0), 64'(1));
        if (exp_wr_addr.size() != 0) begin
          check("write_addr", 64'(S_addr_ram), 64'(exp_wr_addr.pop_front()));
          check("write_data", S_Wdata_ram, exp_wr_dat.pop_front());
        end
      end
      if (S_oe_ram) begin
        obs_oe.push_back(S_addr_ram);
        check("read_expected", 64'(exp_rd_addr.size() != 0), 64'(1));
        if (exp_rd_addr.size() != 0)
          check("read_addr", 64'(S_addr_ram), 64'(exp_rd_addr.pop_front()));
      end
      if (rd_valid && rd_ready) begin
        check("result_expected", 64'(exp_rd_dat.size() != 0), 64'(1));
        if (exp_rd_dat.size() != 0) check("result_data", rd_data, exp_rd_dat.pop_front());
      end
      if (acc_start) begin
        check("start_after_load", 64'(exp_wr_addr.size()), 64'(0));
        check("start_expected", 64'(exp_starts), 64'(1));
        exp_starts = 0;
      end
      if (status_valid) begin
        check("status_expected", 64'(exp_status), 64'(1));
        check("run_cycles", 64'(run_cycles), 64'(exp_run));
        check("timeout_flag", 64'(timeout_flag), 64'(exp_flag));
        check("reads_drained", 64'(exp_rd_addr.size() + exp_rd_dat.size()), 64'(0));
        exp_status = 0;
        obs_status++;
        obs_run  = run_cycles;
        obs_flag = timeout_flag;
        hold_run  = run_cycles;
        hold_flag = timeout_flag;
      end
      prev_rv = rd_valid; prev_rr = rd_ready; prev_rd = rd_data;
      prev_start = acc_start; prev_stat = status_valid;
    end
  end

  // Accelerator: raises done on the cur_delay-th run cycle (0 = never).
  int resp_d;
  initial begin
    acc_done_resp = 1'b0;
    forever begin
      @(negedge clock);
      if (acc_start && !reset && cur_delay > 0) begin
        resp_d = cur_delay;
        repeat (resp_d) @(posedge clock);
        #1 acc_done_resp = 1'b1;
        @(posedge clock);
        #1 acc_done_resp = 1'b0;
      end
    end
  end

  // Slave RAM: returns mem[addr] after 0..3 wait cycles, junk otherwise.
  logic [ADDR_W-1:0] mem_a;
  int                mem_l;
  initial begin
    Sout_DataRdy   = 1'b0;
    Sout_Rdata_ram = '0;
    forever begin
      @(negedge clock);
      if (S_oe_ram && !reset) begin
        mem_a = S_addr_ram;
        mem_l = $urandom_range(0, 3);
        @(posedge clock);
        repeat (mem_l) @(posedge clock);
        #1 Sout_DataRdy = 1'b1;
        Sout_Rdata_ram = mem[mem_a];
        @(posedge clock);
        #1 Sout_DataRdy = 1'b0;
        Sout_Rdata_ram = {$urandom, $urandom};
      end
    end
  end

  // Result sink: random backpressure, or exactly three stall cycles per word.
  int stall_cnt;
  initial begin
    rd_ready  = 1'b0;
    stall_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_mode) begin
        if (rd_valid) begin
          if (stall_cnt == 3) begin rd_ready = 1'b1; stall_cnt = 0; end
          else begin rd_ready = 1'b0; stall_cnt++; end
        end else rd_ready = 1'b0;
      end else rd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] lb, input int lw,
                          input logic [ADDR_W-1:0] rb, input int rw,
                          input int d, input bit gapped);
    logic [DATA_W-1:0] words[$];
    logic [ADDR_W-1:0] a;
    bit   ok;
    int   t, gap;
    ok = (d >= 1) && (d <= TMO);
    for (int i = 0; i < lw; i++) begin
      words.push_back({$urandom, $urandom});
      exp_wr_addr.push_back(ADDR_W'(32'(lb) + 8 * i));
      exp_wr_dat.push_back(words[i]);
    end
    if (ok) begin
      for (int i = 0; i < rw; i++) begin
        a = ADDR_W'(32'(rb) + 8 * i);
        exp_rd_addr.push_back(a);
        exp_rd_dat.push_back(mem[a]);
      end
    end
    exp_run    = ok ? CNT_W'(d) : CNT_W'(TMO);
    exp_flag   = !ok;
    exp_starts = 1;
    exp_status = 1;
    cur_delay  = d;
    obs_wr.delete();
    obs_oe.delete();
    obs_status = 0;
    t = 0;
    while (!cmd_ready && t < 100) begin tick(); t++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid     = 1'b1;
    cmd_ld_base   = lb;
    cmd_ld_words  = 8'(lw);
    cmd_rd_base   = rb;
    cmd_rd_words  = 8'(rw);
    acc_done_spur = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < lw; i++) begin
      gap = gapped ? ((i == 1) ? 2 : 0) : int'($urandom_range(0, 2));
      repeat (gap) tick();
      ld_valid = 1'b1;
      ld_data  = words[i];
      tick();
      ld_valid = 1'b0;
      ld_data  = {$urandom, $urandom};
    end
    acc_done_spur = 1'b0;
  endtask

  task automatic wait_status();
    int t;
    t = 0;
    while (obs_status == 0 && t < 300) begin tick(); t++; end
    check("status_seen", 64'(obs_status), 64'(1));
    repeat (6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  int r, dd;
  initial begin
    reset = 1'b1;
    cmd_valid = 0; cmd_ld_base = '0; cmd_ld_words = '0; cmd_rd_base = '0; cmd_rd_words = '0;
    ld_valid = 0; ld_data = '0; acc_done_spur = 0;
    cur_delay = 0; stall_mode = 0;
    exp_starts = 0; exp_status = 0; exp_run = '0; exp_flag = 0; obs_status = 0;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    repeat (3) tick();
    check("reset_ctrl", 64'({busy, status_valid, acc_start, S_oe_ram, S_we_ram, ld_ready, rd_valid, timeout_flag}), 64'(0));
    check("reset_bus", 64'({S_addr_ram, S_data_ram_size}), 64'(0));
    check("reset_run_cycles", 64'(run_cycles), 64'(0));
    check("reset_rd_data", rd_data, 64'(0));
    @(negedge clock) reset = 1'b0;
    tick();
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    // Two loads, one read-back, done five cycles after start.
    send_cmd(9'h010, 2, 9'h040, 1, 5, 0);
    wait_status();
    check("basic_wr_count", 64'(obs_wr.size()), 64'(2));
    check("basic_wr0", 64'(obs_wr.size() > 0 ? obs_wr[0] : 9'h1FF), 64'(9'h010));
    check("basic_wr1", 64'(obs_wr.size() > 1 ? obs_wr[1] : 9'h1FF), 64'(9'h018));
    check("basic_oe0", 64'(obs_oe.size() > 0 ? obs_oe[0] : 9'h1FF), 64'(9'h040));
    check("basic_run", 64'(obs_run), 64'(5));
    check("basic_flag", 64'(obs_flag), 64'(0));
    check("basic_rd_data", rd_data, mem[9'h040]);

    // Nothing to load or read; done on the first run cycle.
    send_cmd(9'h0AB, 0, 9'h055, 0, 1, 0);
    wait_status();
    check("empty_wr_count", 64'(obs_wr.size() + obs_oe.size()), 64'(0));
    check("empty_run", 64'(obs_run), 64'(1));

    // Timeout, then done landing exactly on the limit.
    send_cmd(9'h000, 1, 9'h080, 2, 0, 0);
    wait_status();
    check("tmo_flag", 64'(obs_flag), 64'(1));
    check("tmo_run", 64'(obs_run), 64'(8));
    check("tmo_no_oe", 64'(obs_oe.size()), 64'(0));
    check("tmo_idle", 64'(busy), 64'(0));
    send_cmd(9'h000, 0, 9'h080, 2, 8, 0);
    wait_status();
    check("limit_flag", 64'(obs_flag), 64'(0));
    check("limit_run", 64'(obs_run), 64'(8));
    check("limit_oe", 64'(obs_oe.size()), 64'(2));

    // Gapped load stream and a three-cycle result stall.
    stall_mode = 1;
    send_cmd(9'h020, 2, 9'h100, 1, 3, 1);
    wait_status();
    stall_mode = 0;
    check("gap_wr0", 64'(obs_wr.size() > 0 ? obs_wr[0] : 9'h1FF), 64'(9'h020));
    check("gap_wr1", 64'(obs_wr.size() > 1 ? obs_wr[1] : 9'h1FF), 64'(9'h028));

    // Address wrap at the top of the slave space.
    send_cmd(9'h1F8, 2, 9'h1F8, 2, 2, 0);
    wait_status();
    check("wrap_wr1", 64'(obs_wr.size() > 1 ? obs_wr[1] : 9'h1FF), 64'(9'h000));
    check("wrap_oe1", 64'(obs_oe.size() > 1 ? obs_oe[1] : 9'h1FF), 64'(9'h000));

    // Reset mid-run aborts silently; the next command runs normally.
    send_cmd(9'h000, 0, 9'h000, 2, 0, 0);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_ctrl", 64'({busy, status_valid, acc_start, S_oe_ram, S_we_ram, ld_ready, rd_valid, timeout_flag}), 64'(0));
    check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    check("abort_run_cycles", 64'(run_cycles), 64'(0));
    exp_wr_addr.delete(); exp_wr_dat.delete(); exp_rd_addr.delete(); exp_rd_dat.delete();
    exp_status = 0; exp_starts = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (12) tick();
    check("abort_no_status", 64'(obs_status), 64'(0));
    send_cmd(9'h0A0, 1, 9'h0B0, 1, 4, 0);
    wait_status();
    check("after_abort_run", 64'(obs_run), 64'(4));

    for (int k = 0; k < 40; k++) begin
      r  = int'($urandom_range(0, 9));
      dd = (r == 0) ? 0 : int'($urandom_range(1, TMO + 2));
      send_cmd(9'($urandom_range(0, 511)), int'($urandom_range(0, 4)),
               9'($urandom_range(0, 511)), int'($urandom_range(0, 4)), dd, 0);
      wait_status();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
